// File: rtl/seed_frame_rx.sv
// seed_frame_rx: receive side of the inter-board seed exchange.
// Decodes the 4-byte frame {SYNC, x, y, SYNC^x^y} from the UART receiver,
// range-checks the seed, and holds the last accepted peer seed until cleared.
// Ports:
//   clk_75, rst        clock and synchronous active-high reset
//   rx_data, rx_valid  received byte and its one-cycle strobe
//   clear              drop held seed and abort any frame in progress
//   seed_x_in/_y_in    last accepted peer seed
//   seed_valid         a good seed is held
//   seed_new           one-cycle pulse on frame accept
//   frame_err          one-cycle pulse on frame reject (bad field, checksum, timeout)
//   err_count          saturating count of rejected frames
module seed_frame_rx #(
   parameter int unsigned TIMEOUT_CYCLES = 750000,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned SEED_X_MAX     = 62,
   parameter int unsigned SEED_Y_MAX     = 46
) (
   input  logic       clk_75,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       clear,
   output logic [5:0] seed_x_in,
   output logic [5:0] seed_y_in,
   output logic       seed_valid,
   output logic       seed_new,
   output logic       frame_err,
   output logic [7:0] err_count
);

   localparam int unsigned   CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]    X_LIM    = 8'(SEED_X_MAX);
   localparam logic [7:0]    Y_LIM    = 8'(SEED_Y_MAX);

   typedef enum logic [1:0] {IDLE, GOT_SYNC, GOT_X, GOT_Y} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [5:0]       x_q, x_d, y_q, y_d;
   logic [5:0]       seed_x_q, seed_x_d, seed_y_q, seed_y_d;
   logic             seed_valid_q, seed_valid_d;
   logic             seed_new_q, seed_new_d;
   logic             frame_err_q, frame_err_d;
   logic [7:0]       err_count_q, err_count_d;
   logic             accept, reject;

   // State and output registers
   always_ff @(posedge clk_75) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         x_q          <= '0;
         y_q          <= '0;
         seed_x_q     <= '0;
         seed_y_q     <= '0;
         seed_valid_q <= 1'b0;
         seed_new_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         err_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         x_q          <= x_d;
         y_q          <= y_d;
         seed_x_q     <= seed_x_d;
         seed_y_q     <= seed_y_d;
         seed_valid_q <= seed_valid_d;
         seed_new_q   <= seed_new_d;
         frame_err_q  <= frame_err_d;
         err_count_q  <= err_count_d;
      end
   end

   // Frame decode, inter-byte timeout and accept/reject bookkeeping
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      x_d          = x_q;
      y_d          = y_q;
      seed_x_d     = seed_x_q;
      seed_y_d     = seed_y_q;
      seed_valid_d = seed_valid_q;
      seed_new_d   = 1'b0;
      frame_err_d  = 1'b0;
      err_count_d  = err_count_q;
      accept       = 1'b0;
      reject       = 1'b0;

      if (clear) begin
         // clear overrides any frame completion in the same cycle
         state_d      = IDLE;
         cnt_d        = '0;
         seed_x_d     = '0;
         seed_y_d     = '0;
         seed_valid_d = 1'b0;
      end else begin
         if (rx_valid) begin
            cnt_d = '0;
            case (state_q)
               IDLE: begin
                  if (rx_data == SYNC_BYTE) state_d = GOT_SYNC;
               end
               GOT_SYNC: begin
                  x_d = rx_data[5:0];
                  if ((rx_data[7:6] != 2'b00) || (rx_data >= X_LIM)) begin
                     reject  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = GOT_X;
                  end
               end
               GOT_X: begin
                  y_d = rx_data[5:0];
                  if ((rx_data[7:6] != 2'b00) || (rx_data >= Y_LIM)) begin
                     reject  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = GOT_Y;
                  end
               end
               GOT_Y: begin
                  if (rx_data == (SYNC_BYTE ^ {2'b00, x_q} ^ {2'b00, y_q})) accept = 1'b1;
                  else                                                      reject = 1'b1;
                  state_d = IDLE;
               end
               default: state_d = IDLE;
            endcase
         end else if (state_q != IDLE) begin
            // A strobe on the expiry cycle wins, so timeout is only checked here
            if (cnt_q == CNT_LAST) begin
               reject  = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else begin
            cnt_d = '0;
         end

         if (accept) begin
            seed_x_d     = x_q;
            seed_y_d     = y_q;
            seed_valid_d = 1'b1;
            seed_new_d   = 1'b1;
         end
         if (reject) begin
            frame_err_d = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
         end
      end
   end

   assign seed_x_in  = seed_x_q;
   assign seed_y_in  = seed_y_q;
   assign seed_valid = seed_valid_q;
   assign seed_new   = seed_new_q;
   assign frame_err  = frame_err_q;
   assign err_count  = err_count_q;

endmodule

// File: tb/tb_seed_frame_rx.sv
// Bench for seed_frame_rx: directed frames push expected accept/reject
// events into a queue; a negedge monitor pops and checks each output pulse.
module tb_seed_frame_rx;

   localparam int unsigned TO = 100;

   logic       clk_75 = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       clear;
   logic [5:0] seed_x_in, seed_y_in;
   logic       seed_valid, seed_new, frame_err;
   logic [7:0] err_count;

   typedef struct {
      bit       is_err;
      int       cyc;
      int       x;
      int       y;
      int       valid;
      int       ecnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   last_cyc = 0;

   seed_frame_rx #(
      .TIMEOUT_CYCLES(TO),
      .SYNC_BYTE     (8'hA5),
      .SEED_X_MAX    (62),
      .SEED_Y_MAX    (46)
   ) dut (
      .clk_75    (clk_75),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .clear     (clear),
      .seed_x_in (seed_x_in),
      .seed_y_in (seed_y_in),
      .seed_valid(seed_valid),
      .seed_new  (seed_new),
      .frame_err (frame_err),
      .err_count (err_count)
   );

   always #5 clk_75 = ~clk_75;
   always @(posedge clk_75) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // One strobe; consecutive calls give back-to-back strobes
   task automatic send(input logic [7:0] b, input logic clr = 1'b0);
      rx_data  = b;
      rx_valid = 1'b1;
      clear    = clr;
      @(posedge clk_75);
      #1;
      rx_valid = 1'b0;
      clear    = 1'b0;
      last_cyc = cyc;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_75);
      #1;
   endtask

   task automatic push(input bit is_err, input int c, input int x, input int y,
                       input int v, input int e);
      exp_t t;
      t.is_err = is_err; t.cyc = c; t.x = x; t.y = y; t.valid = v; t.ecnt = e;
      exp_q.push_back(t);
   endtask

   // Monitor: every seed_new/frame_err pulse must match the next expectation
   always @(negedge clk_75) begin
      if (!rst && (seed_new || frame_err)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse_new_err", {seed_new, frame_err}, 0);
         end else begin
            exp_t t;
            t = exp_q.pop_front();
            chk("pulse_cycle",  cyc,               t.cyc);
            chk("frame_err",    int'(frame_err),   int'(t.is_err));
            chk("seed_new",     int'(seed_new),    int'(!t.is_err));
            chk("seed_x_in",    int'(seed_x_in),   t.x);
            chk("seed_y_in",    int'(seed_y_in),   t.y);
            chk("seed_valid",   int'(seed_valid),  t.valid);
            chk("err_count",    int'(err_count),   t.ecnt);
         end
      end
   end

   initial begin
      rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; clear = 1'b0;
      idle(3);
      rst = 1'b0;
      idle(1);
      chk("rst_seed_x",     int'(seed_x_in),  0);
      chk("rst_seed_y",     int'(seed_y_in),  0);
      chk("rst_seed_valid", int'(seed_valid), 0);
      chk("rst_seed_new",   int'(seed_new),   0);
      chk("rst_frame_err",  int'(frame_err),  0);
      chk("rst_err_count",  int'(err_count),  0);

      // Garbage in IDLE is silent, then a good frame (x=10, y=11)
      send(8'h00); send(8'hFF); send(8'h3C);
      idle(2);
      send(8'hA5); send(8'h0A); send(8'h0B); send(8'hA4);
      push(0, last_cyc, 10, 11, 1, 0);
      idle(3);
      chk("garbage_err_count", int'(err_count), 0);

      // Good frame x=5, y=17
      send(8'hA5); send(8'h05); send(8'h11); send(8'hB1);
      push(0, last_cyc, 5, 17, 1, 0);
      idle(3);

      // x=62 out of range; trailing bytes discarded in IDLE
      send(8'hA5); send(8'h3E);
      push(1, last_cyc, 5, 17, 1, 1);
      send(8'h00); send(8'h9B);
      idle(3);
      chk("range_err_count", int'(err_count), 1);

      // Bad checksum, then an immediately following good frame x=1, y=2
      send(8'hA5); send(8'h05); send(8'h11); send(8'hB0);
      push(1, last_cyc, 5, 17, 1, 2);
      send(8'hA5); send(8'h01); send(8'h02); send(8'hA6);
      push(0, last_cyc, 1, 2, 1, 2);
      idle(3);

      // Stall after x: timeout fires TO cycles after the last strobe
      send(8'hA5); send(8'h05);
      push(1, last_cyc + TO, 1, 2, 1, 3);
      idle(TO + 10);
      send(8'hA5); send(8'h0A); send(8'h0B); send(8'hA4);
      push(0, last_cyc, 10, 11, 1, 3);
      idle(3);

      // clear coincident with the checksum strobe wins
      send(8'hA5); send(8'h05); send(8'h11); send(8'hB1, 1'b1);
      idle(3);
      chk("clear_seed_valid", int'(seed_valid), 0);
      chk("clear_seed_x",     int'(seed_x_in),  0);
      chk("clear_seed_y",     int'(seed_y_in),  0);
      chk("clear_err_count",  int'(err_count),  3);

      // Mid-frame SYNC is data and rejects (y field = 0xA5)
      send(8'hA5); send(8'h05); send(8'hA5);
      push(1, last_cyc, 0, 0, 0, 4);
      send(8'hA5); send(8'h3D); send(8'h2D); send(8'hB5);
      push(0, last_cyc, 61, 45, 1, 4);
      idle(5);

      chk("pending_expectations", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog so the run always ends on its own
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule

// File: doc/seed_frame_rx.md
Name: seed_frame_rx

Overview:
- Receive side of the inter-board seed exchange.
- Takes bytes from the UART receiver, decodes the 4-byte seed frame sent by the peer board when its seed_rdy fires, validates it, and presents the peer seed as seed_x_in/seed_y_in to point generation.
- Holds the last good seed until cleared, and flags malformed or stalled frames.

Parameters:
- TIMEOUT_CYCLES, 750000, max clk_75 cycles allowed between consecutive bytes of one frame (10 ms).
- SYNC_BYTE, 8'hA5, frame header value.
- SEED_X_MAX, 62, seed_x must be < this.
- SEED_Y_MAX, 46, seed_y must be < this.

Ports:
- clk_75  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  8  byte from the UART receiver.
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
- clear  input  1  drops the held seed and aborts any frame in progress (driven on return to MENU).
- seed_x_in  output  6  last accepted peer seed X.
- seed_y_in  output  6  last accepted peer seed Y.
- seed_valid  output  1  level; a good seed is held.
- seed_new  output  1  one-cycle pulse when a frame is accepted.
- frame_err  output  1  one-cycle pulse on any frame rejection.
- err_count  output  8  saturating count of rejected frames.

Behaviour:
- Frame format, in order:
  - B0 = SYNC_BYTE.
  - B1 = {2'b00, x}.
  - B2 = {2'b00, y}.
  - B3 = B0 ^ B1 ^ B2.
- FSM states: IDLE, GOT_SYNC, GOT_X, GOT_Y. Transitions happen only on cycles with rx_valid=1, except timeout and clear.
- IDLE:
  - Byte == SYNC_BYTE → GOT_SYNC.
  - Any other byte is silently discarded: no frame_err, no count.
- GOT_SYNC:
  - Capture the byte into the x register, then → GOT_X.
  - Bits[7:6] != 0 or x >= SEED_X_MAX → reject.
- GOT_X:
  - Capture the byte into the y register, then → GOT_Y.
  - Bits[7:6] != 0 or y >= SEED_Y_MAX → reject.
- GOT_Y:
  - Byte == SYNC_BYTE ^ {2'b00,x} ^ {2'b00,y} → accept.
  - Otherwise → reject.
  - Either way → IDLE.
- SYNC_BYTE arriving mid-frame is treated as data. 0xA5 has bits[7:6]=10, so it rejects. The byte is consumed; there is no resync on it.
- Accept:
  - On the cycle after the B3 strobe: seed_x_in/seed_y_in take the captured x/y, seed_valid=1, and seed_new pulses high for exactly 1 cycle.
  - Outputs then hold until the next accept, clear or rst.
- Reject:
  - On the cycle after the offending strobe, frame_err pulses for 1 cycle and err_count increments (saturates at 255).
  - FSM → IDLE. seed_x_in/seed_y_in/seed_valid are unchanged.
- Timeout:
  - Inter-byte counter resets to 0 on every rx_valid and counts while in a non-IDLE state.
  - When the counter reaches TIMEOUT_CYCLES-1 with no strobe, it is treated as a reject (frame_err, err_count++, → IDLE).
  - Counter is held at 0 in IDLE.
- clear:
  - Next cycle: FSM=IDLE, seed_valid=0, seed_x_in=seed_y_in=0, timeout counter=0.
  - No frame_err is generated. err_count is not affected.
  - clear coincident with a completing B3 strobe: clear wins; no seed_new, seed_valid=0.
- A timeout expiry coincident with rx_valid is not a timeout: the byte is processed normally.
- Reset values: seed_x_in=0, seed_y_in=0, seed_valid=0, seed_new=0, frame_err=0, err_count=0, FSM=IDLE, timeout counter=0.
- rst asserted mid-frame discards the partial frame with no error pulse.
- Width rules:
  - Range compares are done on the full 8-bit byte, so the bits[7:6] check and the range check are both applied.
  - Checksum is computed on 8 bits.
  - Timeout counter width is $clog2(TIMEOUT_CYCLES).
- Throughput: back-to-back strobes on consecutive cycles are legal. A new B0 may arrive on the cycle right after B3.

Test Plan:
1. Bytes A5,05,11,B1 → one cycle after the B1 strobe: seed_x_in=5, seed_y_in=17, seed_valid=1, seed_new=1 for 1 cycle, frame_err never high.
2. Bytes A5,3E,00,9B (x=62) → frame_err pulse after the 3E strobe; err_count=1; outputs unchanged; the trailing 00,9B are discarded in IDLE without error.
3. Bytes A5,05,11,B0 (bad checksum) → frame_err after B0, err_count+1; a following A5,05,11,B1 is accepted normally.
4. A5,05 then idle TIMEOUT_CYCLES (bench param 100) cycles → frame_err exactly once at expiry; then A5,0A,0B,A4 → seed_x_in=10, seed_y_in=11.
5. Garbage 00,FF,3C in IDLE, then a valid frame → no frame_err, err_count stays 0, seed accepted.
6. After an accepted seed, clear asserted in the same cycle as the final checksum strobe of a second frame → seed_valid=0, seeds=0, no seed_new, no frame_err.
